word_serial_addsub: RTL and testbench

Word-serial wide adder/subtractor for the IDDMM datapath. Accepts two N×W-bit operands as N W-bit words, least-significant word first, and streams out the N-word sum or difference with the carry chained between words. It sits downstream of the multiplier core and is used for the final conditional subtraction and for wide accumulation. The per-word add uses one instance of the existing `simple_cclaa_x4bit` cascaded carry look-ahead adder (width W).

---
 rtl/word_serial_addsub_if.sv | 38 +++
 rtl/word_serial_addsub.sv | 194 +++++++++++++++++++
 tb/tb_word_serial_addsub.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_serial_addsub_if.sv
// Stream interface for word_serial_addsub.
// Input stream:  s_valid/s_ready handshake carrying s_a, s_b and s_sub (mode, word 0 only).
// Output stream: m_valid/m_ready handshake carrying m_data, m_last, m_co
//                and, with WORD_SERIAL_ZERO_FLAG_EN defined, m_zero.
// Modports: slave = the adder/subtractor, master = the environment driving it.
interface word_serial_addsub_if #(
    parameter int unsigned W = 64
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    logic         s_sub;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_co;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
    logic         m_zero;
`endif

    modport slave (
        input  s_valid, s_a, s_b, s_sub, m_ready,
        output s_ready, m_valid, m_data, m_last, m_co
`ifdef WORD_SERIAL_ZERO_FLAG_EN
        , output m_zero
`endif
    );

    modport master (
        output s_valid, s_a, s_b, s_sub, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_co
`ifdef WORD_SERIAL_ZERO_FLAG_EN
        , input m_zero
`endif
    );
endinterface

// File: rtl/word_serial_addsub.sv
// Word-serial wide adder/subtractor. Two N*W-bit operands arrive as N W-bit
// words, LS word first; the N-word sum (s_sub=0) or difference (s_sub=1)
// streams out one cycle after each input word, the carry chained between words.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : word_serial_addsub_if.slave (input and output word streams)
// Optional feature macro: WORD_SERIAL_ZERO_FLAG_EN adds bus.m_zero, set with
// m_last when every word of the result is zero.
// Also contains simple_cclaa_x4bit, the cascaded 4-bit carry look-ahead adder
// used for the per-word add.

// Cascaded carry look-ahead adder: WIDTH/4 lookahead groups, carry rippling
// between groups. WIDTH must be a multiple of 4.
module simple_cclaa_x4bit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int unsigned NBLK = WIDTH / 4;

    logic [NBLK:0] c;

    assign c[0] = ci;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;

        assign g     = a[4*k +: 4] & b[4*k +: 4];
        assign p     = a[4*k +: 4] ^ b[4*k +: 4];
        assign cc[0] = c[k];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);
        assign sum[4*k +: 4] = p ^ cc[3:0];
        assign c[k+1]        = cc[4];
    end

    assign co = c[NBLK];
endmodule

module word_serial_addsub #(
    parameter int unsigned W = 64,
    parameter int unsigned N = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    word_serial_addsub_if.slave   bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q,   state_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic          carry_q,   carry_d;
    logic          mode_q,    mode_d;
    logic          m_valid_q, m_valid_d;
    logic [W-1:0]  m_data_q,  m_data_d;
    logic          m_last_q,  m_last_d;
    logic          m_co_q,    m_co_d;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
    logic          zero_run_q, zero_run_d;
    logic          m_zero_q,   m_zero_d;
    logic          zero_acc;
`endif

    logic          in_xfer;
    logic          out_xfer;
    logic          first;
    logic          is_last;
    logic          eff_mode;
    logic [W-1:0]  b_op;
    logic          cin;
    logic [W-1:0]  sum;
    logic          co;

    // Single-register pipeline: accept whenever the output slot frees this cycle.
    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign in_xfer     = bus.s_valid && bus.s_ready;
    assign out_xfer    = m_valid_q && bus.m_ready;

    // Word 0 takes mode and carry-in straight from s_sub so back-to-back
    // operands never inherit the previous operand's mode or carry.
    assign first    = (state_q == IDLE);
    assign is_last  = (idx_q == IW'(N - 1));
    assign eff_mode = first ? bus.s_sub : mode_q;
    assign b_op     = eff_mode ? ~bus.s_b : bus.s_b;
    assign cin      = first ? bus.s_sub : carry_q;

    simple_cclaa_x4bit #(.WIDTH(W)) u_add (
        .a   (bus.s_a),
        .b   (b_op),
        .ci  (cin),
        .sum (sum),
        .co  (co)
    );

`ifdef WORD_SERIAL_ZERO_FLAG_EN
    // Running "all words zero so far", restarted on word 0.
    assign zero_acc = (first ? 1'b1 : zero_run_q) & (sum == '0);
`endif

    // Next-state and output register logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_co_d    = m_co_q;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
        zero_run_d = zero_run_q;
        m_zero_d   = m_zero_q;
`endif
        if (in_xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = sum;
            m_last_d  = is_last;
            m_co_d    = is_last & co;
            carry_d   = co;
            if (first) begin
                mode_d = bus.s_sub;
            end
            if (is_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = RUN;
            end
`ifdef WORD_SERIAL_ZERO_FLAG_EN
            zero_run_d = zero_acc;
            m_zero_d   = is_last & zero_acc;
`endif
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            mode_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_co_q    <= 1'b0;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
            zero_run_q <= 1'b0;
            m_zero_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_co_q    <= m_co_d;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
            zero_run_q <= zero_run_d;
            m_zero_q   <= m_zero_d;
`endif
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_co    = m_co_q;
`ifdef WORD_SERIAL_ZERO_FLAG_EN
    assign bus.m_zero  = m_zero_q;
`endif
endmodule

// File: tb/tb_word_serial_addsub.sv
// Self-checking bench for word_serial_addsub with W=8, N=4 (32-bit operands).
// Expected result words are pushed when an operand is driven and compared
// against words captured from the output stream.
module tb_word_serial_addsub;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    typedef logic [W+2:0] ent_t;   // {data, last, co, zero}

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    word_serial_addsub_if #(.W(W)) bus ();

    word_serial_addsub #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ent_t exp_q[$];
    ent_t obs_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   words_sent = 0;
    bit   rnd_mode  = 1'b0;
    logic rnd_ready = 1'b1;
    logic ready_force = 1'b1;
    logic zero_obs;

    assign bus.m_ready = rnd_mode ? rnd_ready : ready_force;

`ifdef WORD_SERIAL_ZERO_FLAG_EN
    assign zero_obs = bus.m_zero;
`else
    assign zero_obs = 1'b0;
`endif

    // Random downstream readiness, changed only on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            rnd_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Output capture on each output transfer.
    always @(posedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready)
            obs_q.push_back({bus.m_data, bus.m_last, bus.m_co, zero_obs});
    end

    // Reference: full-width add or subtract, carry/no-borrow in bit 32.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] r;
        logic        z;
        r = model(a, b, sub);
`ifdef WORD_SERIAL_ZERO_FLAG_EN
        z = (r[31:0] == 32'd0);
`else
        z = 1'b0;
`endif
        for (int i = 0; i < 4; i++)
            exp_q.push_back({r[8*i +: 8], i == 3, (i == 3) & r[32], (i == 3) & z});
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int budget = 200;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_sub   = sub;
        #1;
        while (!bus.s_ready) begin
            if (budget == 0) begin
                $display("FAIL send_word_timeout: s_ready=0 for %0d cycles, required 1", 200);
                $fatal(1, "input stream stalled");
            end
            budget--;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        words_sent++;
    endtask

    // Later words carry the inverted mode so a design that resamples s_sub is caught.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        push_model(a, b, sub);
        for (int i = 0; i < 4; i++)
            send_word(a[8*i +: 8], b[8*i +: 8], (i == 0) ? sub : ~sub);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int budget = 200;
        while (obs_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.s_sub = 1'b0;
        ready_force = 1'b1;
        #12;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data: got %h, required 00", bus.m_data); else n_pass++;
        n_checks++; if (bus.m_last !== 1'b0) $display("FAIL reset_m_last: got %b, required 0", bus.m_last); else n_pass++;
        n_checks++; if (bus.m_co !== 1'b0) $display("FAIL reset_m_co: got %b, required 0", bus.m_co); else n_pass++;
        n_checks++; if (zero_obs !== 1'b0) $display("FAIL reset_m_zero: got %b, required 0", zero_obs); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b, required 1", bus.s_ready); else n_pass++;
    endtask

    task automatic test_add_ripple();
        logic [31:0] a = 32'h00FFFFFF;
        logic [31:0] b = 32'h00000001;
        logic [7:0]  wexp [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
        ent_t e, o;
        push_model(a, b, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_word(a[8*i +: 8], b[8*i +: 8], 1'b0);
            #1;
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== wexp[i] || bus.m_last !== (i == 3))
                $display("FAIL ripple_latency word %0d: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         i, bus.m_valid, bus.m_data, bus.m_last, wexp[i], (i == 3));
            else n_pass++;
        end
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL ripple_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL ripple_word: got %h, required %h", o, e); else n_pass++;
            end
        end
    endtask

    task automatic test_add_overflow();
        ent_t e, o;
        send_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL overflow_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL overflow_word: got %h, required %h", o, e); else n_pass++;
            end
        end
    endtask

    task automatic test_sub();
        ent_t e, o;
        send_op(32'h00000100, 32'h00000001, 1'b1);
        send_op(32'h00000001, 32'h00000002, 1'b1);
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL sub_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL sub_word: got %h, required %h", o, e); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a = 32'h12345678;
        logic [31:0] b = 32'h0FEDCBA9;
        logic [32:0] r;
        ent_t e, o;
        r = model(a, b, 1'b0);
        words_sent = 0;
        fork
            send_op(a, b, 1'b0);
            begin
                wait (words_sent >= 2);
                @(negedge clk);
                ready_force = 1'b0;
                repeat (3) begin
                    #1;
                    n_checks++;
                    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== r[15:8])
                        $display("FAIL stall_hold: got s_ready=%b valid=%b data=%h, required s_ready=0 valid=1 data=%h",
                                 bus.s_ready, bus.m_valid, bus.m_data, r[15:8]);
                    else n_pass++;
                    @(negedge clk);
                end
                ready_force = 1'b1;
            end
        join
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL stall_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL stall_word: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL stall_extra: got %0d extra words, required 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ent_t e, o;
        send_op(32'h00000000, 32'h00000001, 1'b1);
        send_op(32'h00000001, 32'h00000001, 1'b0);
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL b2b_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b_word: got %h, required %h", o, e); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        ent_t e, o;
        send_word(8'h44, 8'h01, 1'b0);
        send_word(8'h33, 8'h01, 1'b0);
        send_word(8'h22, 8'h01, 1'b0);
        #2;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.m_last !== 1'b0 || bus.m_co !== 1'b0 || zero_obs !== 1'b0)
            $display("FAIL async_reset_outputs: got valid=%b data=%h last=%b co=%b zero=%b, required all 0",
                     bus.m_valid, bus.m_data, bus.m_last, bus.m_co, zero_obs);
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_op(32'h80FF00FF, 32'h7F0100FF, 1'b0);
        idle();
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL post_reset_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL post_reset_word: got %h, required %h", o, e); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        ent_t e, o;
        rnd_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = (($urandom_range(0, 15)) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 31) == 0) a = 32'd0;
            send_op(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        @(negedge clk);
        rnd_mode = 1'b0;
        wait_obs(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL random_word: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL random_word: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL random_extra: got %0d extra words, required 0", obs_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_ripple();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
